// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// Package: mul_pkg
// Purpose: Shared definitions for the multiplier datapath and the product
//          accumulator that follows it.
//          - state_t        : accumulator FSM states (ACCUM / HOLD)
//          - PROD_W         : width of the unsigned multiplier product
//          - DEF_ACC_W      : default accumulator/result width
//          - DEF_MAX_TERMS  : default hard frame length limit
//          - DEF_CNT_W      : default term counter width
// -----------------------------------------------------------------------------
package mul_pkg;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   localparam int PROD_W        = 16;
   localparam int DEF_ACC_W     = 24;
   localparam int DEF_MAX_TERMS = 16;
   localparam int DEF_CNT_W     = 5;

endpackage

// File: rtl/mul_product_accumulator.sv
// -----------------------------------------------------------------------------
// Module: mul_product_accumulator
// Purpose: Sums the 16-bit product stream of the 8x8 multiplier into one frame
//          total. A frame closes on in_last or when MAX_TERMS products have
//          been summed; the total, term count and overflow flag are then held
//          on a valid/ready result port until downstream takes them.
// Ports:
//   clk        in   1       rising-edge clock
//   rst        in   1       synchronous active-high reset
//   in_valid   in   1       product / in_last valid
//   in_ready   out  1       a product can be accepted this cycle
//   product    in   PROD_W  unsigned product
//   in_last    in   1       product is the final term of the frame
//   out_valid  out  1       frame result valid
//   out_ready  in   1       downstream accepts the result
//   acc_out    out  ACC_W   frame sum modulo 2**ACC_W
//   term_cnt   out  CNT_W   number of products in the frame
//   overflow   out  1       some addition in the frame carried out of ACC_W
// -----------------------------------------------------------------------------
module mul_product_accumulator
   import mul_pkg::*;
#(
   parameter int ACC_W     = DEF_ACC_W,
   parameter int MAX_TERMS = DEF_MAX_TERMS,
   parameter int CNT_W     = DEF_CNT_W
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] product,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic [CNT_W-1:0]  term_cnt,
   output logic              overflow
);

   // Parameter sanity: the result must hold one full product and the counter
   // must be able to represent MAX_TERMS.
   if (ACC_W < PROD_W) begin : g_chk_acc_w
      $error("mul_product_accumulator: ACC_W must be >= PROD_W");
   end
   if (MAX_TERMS < 1) begin : g_chk_max_terms
      $error("mul_product_accumulator: MAX_TERMS must be >= 1");
   end
   if ((2 ** CNT_W) <= MAX_TERMS) begin : g_chk_cnt_w
      $error("mul_product_accumulator: 2**CNT_W must exceed MAX_TERMS");
   end

   state_t             r_state;
   state_t             w_next_state;
   logic [ACC_W-1:0]   r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_ovf;
   logic [ACC_W-1:0]   r_acc_out;
   logic [CNT_W-1:0]   r_term_cnt;
   logic               r_overflow;

   logic               w_in_ready;
   logic               w_out_valid;
   logic               w_accept;
   logic               w_emit;
   logic [ACC_W-1:0]   w_base_acc;
   logic [CNT_W-1:0]   w_base_cnt;
   logic               w_base_ovf;
   logic [ACC_W:0]     w_sum;
   logic [CNT_W-1:0]   w_cnt_inc;
   logic               w_ovf_inc;
   logic               w_close;

   assign w_accept = in_valid & w_in_ready;
   assign w_emit   = w_out_valid & out_ready;

   // Operand selection: a product accepted in HOLD is always accompanied by an
   // emit, so it starts a fresh frame from zero instead of the held total.
   always_comb begin
      if (r_state == HOLD) begin
         w_base_acc = {ACC_W{1'b0}};
         w_base_cnt = {CNT_W{1'b0}};
         w_base_ovf = 1'b0;
      end else begin
         w_base_acc = r_acc;
         w_base_cnt = r_cnt;
         w_base_ovf = r_ovf;
      end
   end

   // Single ACC_W+1 adder, counter increment and frame-close detection.
   always_comb begin
      w_sum     = {1'b0, w_base_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, product};
      w_cnt_inc = w_base_cnt + CNT_W'(1'b1);
      w_ovf_inc = w_base_ovf | w_sum[ACC_W];
      w_close   = w_accept & (in_last | (w_cnt_inc == CNT_W'(MAX_TERMS)));
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ACCUM;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ACCUM: begin
            if (w_close) begin
               w_next_state = HOLD;
            end else begin
               w_next_state = ACCUM;
            end
         end
         HOLD: begin
            if (w_close) begin
               w_next_state = HOLD;
            end else if (w_emit) begin
               w_next_state = ACCUM;
            end else begin
               w_next_state = HOLD;
            end
         end
         default: begin
            w_next_state = ACCUM;
         end
      endcase
   end

   // FSM outputs; in_ready follows out_ready only while a result is held.
   always_comb begin
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      case (r_state)
         ACCUM: begin
            w_in_ready  = 1'b1;
            w_out_valid = 1'b0;
         end
         HOLD: begin
            w_in_ready  = out_ready;
            w_out_valid = 1'b1;
         end
         default: begin
            w_in_ready  = 1'b0;
            w_out_valid = 1'b0;
         end
      endcase
   end

   // Running frame state and result register set.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc      <= {ACC_W{1'b0}};
         r_cnt      <= {CNT_W{1'b0}};
         r_ovf      <= 1'b0;
         r_acc_out  <= {ACC_W{1'b0}};
         r_term_cnt <= {CNT_W{1'b0}};
         r_overflow <= 1'b0;
      end else if (w_accept) begin
         r_acc <= w_sum[ACC_W-1:0];
         r_cnt <= w_cnt_inc;
         r_ovf <= w_ovf_inc;
         if (w_close) begin
            r_acc_out  <= w_sum[ACC_W-1:0];
            r_term_cnt <= w_cnt_inc;
            r_overflow <= w_ovf_inc;
         end else begin
            r_acc_out  <= r_acc_out;
            r_term_cnt <= r_term_cnt;
            r_overflow <= r_overflow;
         end
      end else if (w_emit) begin
         r_acc <= {ACC_W{1'b0}};
         r_cnt <= {CNT_W{1'b0}};
         r_ovf <= 1'b0;
      end else begin
         r_acc <= r_acc;
         r_cnt <= r_cnt;
         r_ovf <= r_ovf;
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = w_out_valid;
   assign acc_out   = r_acc_out;
   assign term_cnt  = r_term_cnt;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_mul_product_accumulator.sv
// -----------------------------------------------------------------------------
// Testbench: tb_mul_product_accumulator
// Purpose: Drives two accumulators (ACC_W=24 and ACC_W=16, same stimulus) with
//          directed frames and random traffic, comparing every cycle against a
//          frame-level reference model built from a queue of accepted terms.
// -----------------------------------------------------------------------------
module tb_mul_product_accumulator;
   import mul_pkg::*;

   localparam int AW_A = 24;
   localparam int AW_B = 16;
   localparam int MT   = 16;
   localparam int CW   = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic [PROD_W-1:0] product;
   logic              in_last;
   logic              out_ready;

   logic              in_ready_a, out_valid_a, ovf_a;
   logic [AW_A-1:0]   acc_a;
   logic [CW-1:0]     cnt_a;
   logic              in_ready_b, out_valid_b, ovf_b;
   logic [AW_B-1:0]   acc_b;
   logic [CW-1:0]     cnt_b;

   always #5 clk = ~clk;

   mul_product_accumulator #(.ACC_W(AW_A), .MAX_TERMS(MT), .CNT_W(CW)) u_dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
      .product(product), .in_last(in_last), .out_valid(out_valid_a),
      .out_ready(out_ready), .acc_out(acc_a), .term_cnt(cnt_a), .overflow(ovf_a)
   );

   mul_product_accumulator #(.ACC_W(AW_B), .MAX_TERMS(MT), .CNT_W(CW)) u_dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
      .product(product), .in_last(in_last), .out_valid(out_valid_b),
      .out_ready(out_ready), .acc_out(acc_b), .term_cnt(cnt_b), .overflow(ovf_b)
   );

   int n_tests = 0;
   int n_fails = 0;

   // Reference model: terms of the open frame plus the pending (held) result.
   longint unsigned terms[$];
   bit              m_hold = 1'b0;
   longint unsigned m_acc_a = 0;
   longint unsigned m_acc_b = 0;
   bit              m_ovf_a = 1'b0;
   bit              m_ovf_b = 1'b0;
   int              m_cnt = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Frame total modulo 2**w; overflow if any running sum reaches 2**w.
   function automatic void frame_total(input int w, output longint unsigned tot, output bit ovf);
      longint unsigned s;
      longint unsigned lim;
      lim = 64'd1 << w;
      tot = 0;
      ovf = 1'b0;
      foreach (terms[i]) begin
         s = tot + terms[i];
         if (s >= lim) ovf = 1'b1;
         tot = s % lim;
      end
   endfunction

   // One clock: compare outputs at the negedge, advance the model, step to posedge+1.
   task automatic cycle(input bit do_check);
      bit acc_ok;
      @(negedge clk);
      if (do_check) begin
         check("in_ready_a", 64'(in_ready_a), 64'(!m_hold || out_ready));
         check("in_ready_b", 64'(in_ready_b), 64'(!m_hold || out_ready));
         check("out_valid_a", 64'(out_valid_a), 64'(m_hold));
         check("out_valid_b", 64'(out_valid_b), 64'(m_hold));
         if (m_hold) begin
            check("acc_a", 64'(acc_a), m_acc_a);
            check("cnt_a", 64'(cnt_a), 64'(m_cnt));
            check("ovf_a", 64'(ovf_a), 64'(m_ovf_a));
            check("acc_b", 64'(acc_b), m_acc_b);
            check("cnt_b", 64'(cnt_b), 64'(m_cnt));
            check("ovf_b", 64'(ovf_b), 64'(m_ovf_b));
         end
      end
      if (rst) begin
         terms.delete();
         m_hold = 1'b0;
      end else begin
         acc_ok = in_valid && (!m_hold || out_ready);
         if (m_hold && out_ready) m_hold = 1'b0;
         if (acc_ok) begin
            terms.push_back(longint'(product));
            if (in_last || terms.size() == MT) begin
               frame_total(AW_A, m_acc_a, m_ovf_a);
               frame_total(AW_B, m_acc_b, m_ovf_b);
               m_cnt  = terms.size();
               m_hold = 1'b1;
               terms.delete();
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [PROD_W-1:0] p, input bit l, input bit ordy);
      in_valid  = v;
      product   = p;
      in_last   = l;
      out_ready = ordy;
      cycle(1'b1);
   endtask

   initial begin
      // Reset held two cycles with a valid last term on the input.
      rst = 1'b1; in_valid = 1'b1; product = 16'd55; in_last = 1'b1; out_ready = 1'b1;
      cycle(1'b0);
      cycle(1'b1);
      rst = 1'b0;
      check("rst_out_valid", 64'(out_valid_a), 64'd0);
      check("rst_in_ready", 64'(in_ready_a), 64'd1);
      check("rst_acc_out", 64'(acc_a), 64'd0);
      check("rst_term_cnt", 64'(cnt_a), 64'd0);
      check("rst_overflow", 64'(ovf_a), 64'd0);
      drive(1'b0, 16'd0, 1'b0, 1'b1);
      check("rst_no_accept", 64'(out_valid_a), 64'd0);

      // Frame 3,5,7.
      drive(1'b1, 16'd3, 1'b0, 1'b1);
      drive(1'b1, 16'd5, 1'b0, 1'b1);
      drive(1'b1, 16'd7, 1'b1, 1'b1);
      check("f357_valid", 64'(out_valid_a), 64'd1);
      check("f357_acc", 64'(acc_a), 64'd15);
      check("f357_cnt", 64'(cnt_a), 64'd3);
      check("f357_ovf", 64'(ovf_a), 64'd0);
      drive(1'b0, 16'd0, 1'b0, 1'b1);
      check("f357_drained", 64'(out_valid_a), 64'd0);

      // MAX_TERMS auto-close with 0xFFFF terms.
      for (int i = 0; i < MT; i++) drive(1'b1, 16'hFFFF, 1'b0, 1'b1);
      check("max_valid", 64'(out_valid_a), 64'd1);
      check("max_acc_a", 64'(acc_a), 64'h0FFFF0);
      check("max_cnt_a", 64'(cnt_a), 64'd16);
      check("max_ovf_a", 64'(ovf_a), 64'd0);
      check("max_acc_b", 64'(acc_b), 64'hFFF0);
      check("max_ovf_b", 64'(ovf_b), 64'd1);
      drive(1'b0, 16'd0, 1'b0, 1'b1);

      // Backpressure: result 100 held while out_ready is low.
      drive(1'b1, 16'd40, 1'b0, 1'b0);
      drive(1'b1, 16'd60, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 16'd77, 1'b0, 1'b0);
         check("bp_in_ready", 64'(in_ready_a), 64'd0);
         check("bp_acc_stable", 64'(acc_a), 64'd100);
      end
      drive(1'b1, 16'd8, 1'b0, 1'b1);
      check("bp_emitted", 64'(out_valid_a), 64'd0);
      drive(1'b1, 16'd2, 1'b1, 1'b1);
      check("bp_next_acc", 64'(acc_a), 64'd10);
      check("bp_next_cnt", 64'(cnt_a), 64'd2);

      // Back-to-back single-term frames.
      drive(1'b1, 16'd9, 1'b1, 1'b1);
      check("b2b_9", 64'(acc_a), 64'd9);
      check("b2b_9_valid", 64'(out_valid_a), 64'd1);
      drive(1'b1, 16'd4, 1'b1, 1'b1);
      check("b2b_4", 64'(acc_a), 64'd4);
      check("b2b_4_valid", 64'(out_valid_a), 64'd1);
      drive(1'b1, 16'd2, 1'b1, 1'b1);
      check("b2b_2", 64'(acc_a), 64'd2);
      check("b2b_2_cnt", 64'(cnt_a), 64'd1);
      drive(1'b0, 16'd0, 1'b0, 1'b1);

      // Reset in the middle of a frame discards the partial sum.
      drive(1'b1, 16'd10, 1'b0, 1'b1);
      drive(1'b1, 16'd20, 1'b0, 1'b1);
      rst = 1'b1;
      drive(1'b1, 16'd30, 1'b0, 1'b1);
      rst = 1'b0;
      check("mid_rst_valid", 64'(out_valid_a), 64'd0);
      drive(1'b1, 16'd1, 1'b0, 1'b1);
      drive(1'b1, 16'd1, 1'b1, 1'b1);
      check("mid_rst_acc", 64'(acc_a), 64'd2);
      check("mid_rst_cnt", 64'(cnt_a), 64'd2);
      drive(1'b0, 16'd0, 1'b0, 1'b1);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         drive(($urandom_range(0, 3) != 0),
               ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom),
               ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 9) < 7));
      end
      rst = 1'b0;
      drive(1'b0, 16'd0, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
      $finish;
   end

endmodule
